// File: rtl/fetch_unit_if.sv
// Fetch unit bus: dispatch control, instruction-memory handshake and queue-head outputs.
// The master modport is the fetch unit's view; slave is the surrounding pipeline/memory.
interface fetch_unit_if;
    logic        in_stall;
    logic        in_redirect;
    logic [63:0] in_redirect_pc;
    logic        out_imem_req;
    logic [63:0] out_imem_addr;
    logic        in_imem_gnt;
    logic        in_imem_valid;
    logic [31:0] in_imem_data;
    logic [31:0] out_fetch_insnbits;
    logic [63:0] out_fetch_pc;
    logic        out_fetch_done;
    logic        out_halted;

    modport master (
        input  in_stall, in_redirect, in_redirect_pc, in_imem_gnt, in_imem_valid, in_imem_data,
        output out_imem_req, out_imem_addr, out_fetch_insnbits, out_fetch_pc, out_fetch_done,
        output out_halted
    );

    modport slave (
        output in_stall, in_redirect, in_redirect_pc, in_imem_gnt, in_imem_valid, in_imem_data,
        input  out_imem_req, out_imem_addr, out_fetch_insnbits, out_fetch_pc, out_fetch_done,
        input  out_halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, small in-order instruction queue,
// static B/BL target computation, HLT detection and redirect flush.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 2
) (
    input  logic         in_clk,
    input  logic         in_rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {RUN, WAIT, DRAIN, HALT} state_e;

    state_e        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic          req_q, req_d;
    logic          halted_q, halted_d;
    logic [CW-1:0] count_q, count_d, count_pop;
    logic [63:0]   qpc_q   [QDEPTH];
    logic [63:0]   qpc_d   [QDEPTH];
    logic [31:0]   qinsn_q [QDEPTH];
    logic [31:0]   qinsn_d [QDEPTH];
    logic          pop, enq, is_hlt, is_branch;
    logic [63:0]   next_pc;

    always_comb begin
        is_hlt    = (bus.in_imem_data[31:21] == 11'b11010100010) && (bus.in_imem_data[4:0] == 5'b0);
        // B (000101) and BL (100101) differ only in bit 31
        is_branch = (bus.in_imem_data[30:26] == 5'b00101);
        next_pc   = is_branch ? pc_q + {{36{bus.in_imem_data[25]}}, bus.in_imem_data[25:0], 2'b00}
                              : pc_q + 64'd4;
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        pc_d      = pc_q;
        halted_d  = halted_q;
        count_d   = count_q;
        count_pop = count_q;
        qpc_d     = qpc_q;
        qinsn_d   = qinsn_q;
        pop       = 1'b0;
        enq       = 1'b0;

        if (bus.in_redirect) begin
            // Redirect wins over any same-cycle response, enqueue or pop.
            pc_d     = bus.in_redirect_pc;
            halted_d = 1'b0;
            count_d  = '0;
            case (state_q)
                WAIT, DRAIN: state_d = bus.in_imem_valid ? RUN : DRAIN;
                default:     state_d = RUN;
            endcase
        end else begin
            pop = (count_q != '0) && !bus.in_stall;
            case (state_q)
                RUN: if (req_q && bus.in_imem_gnt) state_d = WAIT;
                WAIT: begin
                    if (bus.in_imem_valid) begin
                        enq  = 1'b1;
                        pc_d = next_pc;
                        if (is_hlt) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                DRAIN: if (bus.in_imem_valid) state_d = RUN;
                default: state_d = HALT;
            endcase

            count_pop = count_q - CW'(pop);
            if (pop) begin
                for (int i = 0; i < QDEPTH - 1; i++) begin
                    qpc_d[i]   = qpc_q[i+1];
                    qinsn_d[i] = qinsn_q[i+1];
                end
            end
            if (enq) begin
                for (int i = 0; i < QDEPTH; i++) begin
                    if (count_pop == CW'(i)) begin
                        qpc_d[i]   = pc_q;
                        qinsn_d[i] = bus.in_imem_data;
                    end
                end
            end
            count_d = count_pop + CW'(enq);
        end

        // Credit check on next occupancy keeps the queue from ever overflowing.
        req_d = (state_d == RUN) && (count_d < CW'(QDEPTH));
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (in_rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    // NOTE: queue payload is not reset; count_q gates every read of it.
    always_ff @(posedge in_clk) begin
        qpc_q   <= qpc_d;
        qinsn_q <= qinsn_d;
    end

    assign bus.out_imem_req       = req_q;
    assign bus.out_imem_addr      = req_q ? pc_q : 64'h0;
    assign bus.out_fetch_done     = (count_q != '0);
    assign bus.out_fetch_insnbits = bus.out_fetch_done ? qinsn_q[0] : 32'h0;
    assign bus.out_fetch_pc       = bus.out_fetch_done ? qpc_q[0] : 64'h0;
    assign bus.out_halted         = halted_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, giving the PC of the first fetch after reset.
REQ-002 SHALL have parameter QDEPTH, default 2, giving the number of instruction queue entries (fixed at 2 in this revision).
REQ-003 SHALL have one clock and one reset: in_clk input 1, the single clock; in_rst input 1, asynchronous active-high reset.
REQ-004 SHALL have in_stall input 1: downstream dispatch cannot accept this cycle.
REQ-005 SHALL have in_redirect input 1: flush and restart at in_redirect_pc.
REQ-006 SHALL have in_redirect_pc input 64: the restart PC.
REQ-007 SHALL have out_imem_req output 1: instruction memory request valid.
REQ-008 SHALL have out_imem_addr output 64: the request PC.
REQ-009 SHALL have in_imem_gnt input 1: the request is accepted this cycle.
REQ-010 SHALL have in_imem_valid input 1 and in_imem_data input 32: the response, arriving in order, 1 or more cycles after grant.
REQ-011 SHALL have out_fetch_insnbits output 32, out_fetch_pc output 64 and out_fetch_done output 1 (head entry valid), all driving dispatch.
REQ-012 SHALL have out_halted output 1: a HLT has been fetched and fetching has stopped.

Function
REQ-013 SHALL hold at most one outstanding memory request; states RUN, WAIT, DRAIN, HALT.
REQ-014 SHALL, in RUN, assert out_imem_req with out_imem_addr = PC when queue occupancy < QDEPTH, and SHALL hold the request stable until in_imem_gnt; on grant SHALL move to WAIT.
REQ-015 SHALL, in WAIT on in_imem_valid, enqueue {PC, in_imem_data} and return to RUN, or go to HALT if the data matches HLT (bits[31:21]=11010100010, bits[4:0]=00000).
REQ-016 SHALL compute next PC at response time: B (bits[31:26]=000101) and BL (100101) give PC + sign-extend(imm26<<2), mod 2^64; all other instructions give PC + 4.
REQ-017 SHALL issue the next request no earlier than the cycle after the response (1 instruction per 2 cycles at best with 1-cycle memory).
REQ-018 SHALL present the queue head combinationally; out_fetch_done = queue non-empty; the head is popped when out_fetch_done && !in_stall.
REQ-019 SHALL, with the queue empty, drive out_fetch_insnbits = 0 and out_fetch_pc = 0.
REQ-020 SHALL allow enqueue and pop in the same cycle, with occupancy unchanged; the credit rule of REQ-014 guarantees no enqueue to a full queue.
REQ-021 SHALL, on in_redirect, flush the queue, set PC = in_redirect_pc and clear out_halted next cycle; from RUN/HALT go to RUN; from WAIT go to DRAIN.
REQ-022 SHALL, if in_redirect arrives while a request is requested but not yet granted, drop that request, and the same cycle's grant is ignored.
REQ-023 SHALL, in DRAIN, discard the next in_imem_valid response and then go to RUN; a further redirect in DRAIN only updates PC.
REQ-024 SHALL give redirect priority over same-cycle response, enqueue and pop: the response is discarded and no pop occurs.
REQ-025 SHALL, in HALT, issue no requests while still draining queued instructions to dispatch; out_halted = 1.

Reset
REQ-026 SHALL, on in_rst asserted (asynchronous), immediately set state RUN, PC = RESET_PC, queue empty, all outputs 0.
REQ-027 SHALL treat a response returning after reset deassertion for a pre-reset request as undefined; the memory is reset together with this block.
REQ-028 SHALL assert first out_imem_req in the first cycle after in_rst deasserts.

Verification
REQ-029 Reset, 1-cycle memory returning 0xD503201F (NOP) always -> out_imem_addr 0x0, 0x4, 0x8 on alternate cycles; out_fetch_done pulses with matching out_fetch_pc.
REQ-030 B at PC 0x10 with imm26 = 0x3FFFFFE (-2) -> next out_imem_addr = 0x8.
REQ-031 in_stall held high for 6 cycles -> exactly 2 entries queued, out_imem_req low, head stays PC 0x0; on release, 0x0 and 0x4 popped on consecutive cycles.
REQ-032 Redirect to 0x400 while in WAIT, same cycle as response -> response dropped, queue empty, next out_imem_addr = 0x400.
REQ-033 Fetch 0xD4400000 (HLT) at 0x20 -> queued, out_halted = 1, no further out_imem_req; then redirect to 0x100 -> out_halted = 0, fetch resumes at 0x100.
REQ-034 in_rst asserted mid-WAIT with 2 queued entries -> out_fetch_done = 0 without waiting for a clock edge; after release, first address = RESET_PC.
